// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a hi/lo pair, either as one 2*WIDTH value
// (pair_i=1, controlled by neg_hi_i) or as two independent WIDTH values.
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    input  logic             pair_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] pair_neg;

    assign pair_neg = -{hi_i, lo_i};

    always_comb begin
        if (pair_i) begin
            {hi_o, lo_o} = neg_hi_i ? pair_neg : {hi_i, lo_i};
        end else begin
            hi_o = neg_hi_i ? -hi_i : hi_i;
            lo_o = neg_lo_i ? -lo_i : lo_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide producing HI/LO.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies stop once remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, ready_q, ready_d, div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     a_abs, b_abs, res_hi, res_lo, fix_hi_in, fix_lo_in;
    logic                 sgn, xor_msb, res_is_mul, early_done;
    logic [WIDTH:0]       rem_shift, div_diff, div_rem;

    assign sgn     = op_is_signed(op);
    assign xor_msb = a[WIDTH-1] ^ b[WIDTH-1];

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .hi_i     (a),
        .lo_i     (b),
        .neg_hi_i (sgn & a[WIDTH-1]),
        .neg_lo_i (sgn & b[WIDTH-1]),
        .pair_i   (1'b0),
        .hi_o     (a_abs),
        .lo_o     (b_abs)
    );

    // Multiply corrects the full 2W product; divide corrects remainder and quotient separately.
    assign res_is_mul = ~op_is_div(op_q);
    assign fix_hi_in  = res_is_mul ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    assign fix_lo_in  = res_is_mul ? acc_q[WIDTH-1:0] : opa_q[WIDTH-1:0];

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_res (
        .hi_i     (fix_hi_in),
        .lo_i     (fix_lo_in),
        .neg_hi_i (neg_hi_q),
        .neg_lo_i (neg_lo_q),
        .pair_i   (res_is_mul),
        .hi_o     (res_hi),
        .lo_o     (res_lo)
    );

    // Restoring step: a clear top bit of the difference means the divisor fit.
    assign rem_shift = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    assign div_diff  = rem_shift - {1'b0, opb_q};
    assign div_rem   = div_diff[WIDTH] ? rem_shift : div_diff;

`ifdef MULDIV_EARLY_TERM_EN
    assign early_done = res_is_mul && (opb_q[WIDTH-1:1] == '0);
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    dz_d = 1'b0;
                    if (op_is_div(op) && (b == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d  = CALC;
                        cnt_d    = CW'(WIDTH);
                        acc_d    = '0;
                        opa_d    = {{WIDTH{1'b0}}, a_abs};
                        opb_d    = b_abs;
                        neg_hi_d = op_is_div(op) ? (sgn & a[WIDTH-1]) : (sgn & xor_msb);
                        neg_lo_d = sgn & xor_msb;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_is_div(op_q)) begin
                    acc_d             = '0;
                    acc_d[WIDTH:0]    = div_rem;
                    opa_d[WIDTH-1:0]  = {opa_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if ((cnt_q == CW'(1)) || early_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_q == CALC) || (state_q == FIX);
        ready_d    = (state_q == DONE);
        div_zero_d = (state_q == DONE) && dz_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            neg_hi_q   <= neg_hi_d;
            neg_lo_q   <= neg_lo_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign div_zero = div_zero_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide engine producing HI/LO results for the multicycle CPU datapath. It replaces the separate fixed 32-bit multiplier and divider with a single unit. It adds signed/unsigned modes, a busy indication and defined overflow/divide-by-zero handling. The control unit starts it with a one-cycle pulse and waits for ready before writing the HI/LO registers.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are WIDTH each; must be >= 4.
CW, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request pulse; sampled only in IDLE
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
a  input  WIDTH  multiplicand / dividend, sampled with start
b  input  WIDTH  multiplier / divisor, sampled with start
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
busy  output  1  high from the cycle after start is accepted until ready
ready  output  1  one-cycle completion pulse
div_zero  output  1  one-cycle pulse coincident with ready when a DIV/DIVU has b==0

Behaviour:
- One clock (clk); asynchronous active-high reset (reset). Reset forces: state IDLE, hi=0, lo=0, busy=0, ready=0, div_zero=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE to CALC on start:
  - Latch op.
  - For signed ops, latch |a| and |b| and record result signs: product sign = a^b MSB; quotient sign = a^b MSB; remainder sign = a MSB.
  - Clear the accumulator and load counter = WIDTH.
- IDLE to DONE (divide by zero): on start with op[1]=1 and b==0. No CALC. hi/lo keep their previous values. div_zero is asserted in DONE.
- CALC processes one bit per cycle and decrements the counter. It moves to FIX when the counter reaches 1 on the current edge, i.e. exactly WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring divide on a WIDTH+1 partial remainder.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Register the results: hi = product[2W-1:W] / remainder; lo = product[W-1:0] / quotient.
- DONE (1 cycle): ready=1, busy=0, then return to IDLE.
- Latency: ready is high in the cycle starting WIDTH+2 edges after the start-sampling edge (34 for WIDTH=32). For divide-by-zero, ready is high one edge after.
- Arithmetic rules:
  - Signed overflow (a = most negative, b = -1, DIV): lo = most negative, hi = 0. This is wrap-around and no exception is raised.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- start while busy (CALC/FIX/DONE) is ignored, and a/b changes during the operation have no effect.
- An illegal state decodes to IDLE.
- hi/lo hold their values between operations. They change only in FIX, or on reset.
- Reset mid-operation aborts immediately. Outputs go to their reset values and no ready is produced.

Optional Feature:
MULDIV_EARLY_TERM_EN:
- When defined, MULT/MULTU leaves CALC for FIX as soon as the remaining multiplier bits are all zero. Minimum multiply latency is 3 (b==0); ready is still exactly one cycle after FIX. Divide latency is unchanged.
- When undefined, every multiply takes the fixed WIDTH+2 latency.
- Results are identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - State encodings: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
- One sub-module, muldiv_sign_fix: combinational two's-complement negate-if-sign for the hi/lo pair. It is used both for operand absolute values and for result correction.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; ready at edge 34; busy high edges 1..33.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, div_zero=0.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU a=00000064, b=00000007 -> lo=0000000E, hi=00000002.
- DIVU a=00000064, b=0 following a prior result (hi=1, lo=2) -> ready and div_zero pulse on edge 1; hi=1, lo=2 unchanged.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, no div_zero.
- Start MULT, then:
  - Assert start again at CALC cycle 5 -> ignored.
  - Assert reset at CALC cycle 10 -> busy=0, hi=lo=0, no ready.
  - A new start after reset is released completes normally.
  - With MULDIV_EARLY_TERM_EN, MULT b=1 -> ready at edge 3.
